can_trailer_tx: RTL and testbench
=================================

// Module: can_trailer_tx
// PURPOSE
//  Transmit-side counterpart of the frame-trailer checks in the decoder. After the data field,
//  serialises the stuffed CRC sequence, CRC delimiter, ACK slot, ACK delimiter, EOF and intermission onto TX.
//  Bit-monitors RX at each sample point and flags bit and ACK errors.
//  Drives active-low field markers F_CRC_D/F_ACK_D with the same meaning the receiver uses.
// PARAMETERS
//  CRC_W     15  CRC sequence width, sent MSB first
//  STUFF_LIM 5   equal consecutive bits before a stuff bit is inserted
//  EOF_LEN   7   recessive EOF bits
//  IFS_LEN   3   recessive intermission bits
// PORTS
//  clk        in  1      system clock; all state updates on posedge
//  reset      in  1      asynchronous, active-low; 0 forces reset state
//  START      in  1      1-clk pulse; latches CRC_IN, PREV_BIT, PREV_RUN; accepted only when BUSY=0
//  CRC_IN     in  CRC_W  CRC value to send
//  PREV_BIT   in  1      last bit sent before CRC field (stuff history)
//  PREV_RUN   in  3      run length of PREV_BIT ending the data field, 1..STUFF_LIM-1
//  BIT_START  in  1      1-clk strobe at start of each bit time; TX/state advance here
//  SP         in  1      1-clk strobe at sample point; RX checked here
//  RX         in  1      bus level (1 = recessive)
//  TX         out 1      bus drive (1 = recessive)
//  BUSY       out 1      1 from accepted START until DONE or abort
//  DONE       out 1      1-clk pulse, trailer completed without error
//  F_CRC_D    out 1      0 while the CRC delimiter bit is on TX, else 1
//  F_ACK_D    out 1      0 while the ACK delimiter bit is on TX, else 1
//  ACK_Error  out 1      active-low, sticky: no dominant ACK seen
//  BIT_Error  out 1      active-low, sticky: RX != TX at SP in a monitored bit
// BEHAVIOUR
//  Reset values: TX=1, BUSY=0, DONE=0, F_CRC_D=1, F_ACK_D=1, ACK_Error=1, BIT_Error=1, state=IDLE.
//  Reset mid-frame: same values immediately (async); the frame is abandoned.
//  States: IDLE, CRC, CRC_DEL, ACK_SLOT, ACK_DEL, EOF, IFS. Transitions happen only on BIT_START.
//  IDLE:
//    - START latches inputs, sets BUSY=1 and clears both error flags to 1; TX stays 1.
//    - First CRC bit is driven at the next BIT_START.
//  CRC:
//    - Per BIT_START, drive the next CRC bit, or a stuff bit when run==STUFF_LIM.
//    - Stuff bit = ~last bit; run resets to 1. Run is seeded from PREV_BIT/PREV_RUN.
//    - Stuff bits do not advance the CRC bit index.
//    - A stuff bit is also inserted after bit 0 if run reaches STUFF_LIM; then go CRC_DEL.
//  CRC_DEL: TX=1, F_CRC_D=0.
//  ACK_SLOT: TX=1; at SP, RX=1 -> ACK_Error=0 and abort.
//  ACK_DEL: TX=1, F_ACK_D=0.
//  EOF: TX=1 for EOF_LEN bits.
//  IFS: TX=1 for IFS_LEN bits. On the BIT_START that ends the last IFS bit: IDLE, BUSY=0, DONE=1 for 1 clk.
//  Monitoring at SP:
//    - CRC (incl. stuff), CRC_DEL, ACK_DEL and EOF bits 1..EOF_LEN-1: RX!=TX -> BIT_Error=0, abort.
//    - Last EOF bit and IFS bits are not monitored (overload handled elsewhere).
//  Abort: on the same clk go IDLE, TX=1, BUSY=0, markers=1, no DONE; error flag holds until next START.
//  Markers/TX are registered and change on the BIT_START clk. Latency: START -> first CRC bit = next BIT_START.
//  SP and BIT_START in same clk: SP check uses the current bit, then advance.
//  START while BUSY=1: ignored, no effect on latched values.
// TESTING
//  - CRC_IN=15'h4A3B, PREV_BIT=0, PREV_RUN=1, RX=TX, ACK dominant -> 15 CRC bits MSB first, no stuff;
//    F_CRC_D=0 one bit; F_ACK_D=0 one bit; DONE after 1+15+1+1+1+7+3 bit times.
//  - CRC_IN=15'h0000, PREV_BIT=0, PREV_RUN=4 -> stuff 1 after first CRC bit, then every 5 zeros; 3 stuff bits total.
//  - Same frame, RX held 1 in ACK slot -> ACK_Error=0 at that SP; BUSY=0; TX=1; no DONE; BIT_Error stays 1.
//  - RX forced 0 while TX=1 on 3rd CRC bit -> BIT_Error=0 at that SP, abort.
//  - RX=0 on last EOF bit -> no error, DONE still asserted.
//  - reset=0 during EOF -> all outputs at reset values; new START afterwards sends a fresh, correct trailer.

Source files
------------

// File: rtl/can_trailer_tx.sv
// rtl/can_trailer_tx.sv - CAN frame trailer transmitter: stuffed CRC, delimiters, ACK, EOF, IFS with bit monitoring
module can_trailer_tx #(
    parameter int CRC_W     = 15,
    parameter int STUFF_LIM = 5,
    parameter int EOF_LEN   = 7,
    parameter int IFS_LEN   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             START,
    input  logic [CRC_W-1:0] CRC_IN,
    input  logic             PREV_BIT,
    input  logic [2:0]       PREV_RUN,
    input  logic             BIT_START,
    input  logic             SP,
    input  logic             RX,
    output logic             TX,
    output logic             BUSY,
    output logic             DONE,
    output logic             F_CRC_D,
    output logic             F_ACK_D,
    output logic             ACK_Error,
    output logic             BIT_Error
);

    localparam int IW      = (CRC_W > 1) ? $clog2(CRC_W) : 1;
    localparam int CNT_MAX = (EOF_LEN > IFS_LEN) ? EOF_LEN : IFS_LEN;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, CRC, CRC_DEL, ACK_SLOT, ACK_DEL, EOF, IFS
    } state_t;

    state_t           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             last_q, last_d;
    logic [2:0]       run_q, run_d;
    logic             sent_all_q, sent_all_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fcrc_q, fcrc_d;
    logic             fack_q, fack_d;
    logic             ack_err_q, ack_err_d;
    logic             bit_err_q, bit_err_d;

    logic             data_bit;
    logic [2:0]       data_run;
    logic             monitored;
    logic             bit_fail;
    logic             ack_fail;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            crc_q      <= '0;
            idx_q      <= '0;
            last_q     <= 1'b0;
            run_q      <= 3'd0;
            sent_all_q <= 1'b0;
            cnt_q      <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fcrc_q     <= 1'b1;
            fack_q     <= 1'b1;
            ack_err_q  <= 1'b1;
            bit_err_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            run_q      <= run_d;
            sent_all_q <= sent_all_d;
            cnt_q      <= cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fcrc_q     <= fcrc_d;
            fack_q     <= fack_d;
            ack_err_q  <= ack_err_d;
            bit_err_q  <= bit_err_d;
        end
    end

    // Next CRC data bit and the run length it would produce
    assign data_bit = crc_q[idx_q];
    assign data_run = (data_bit == last_q) ? run_q + 3'd1 : 3'd1;

    // The final EOF bit is left unmonitored so an overload flag there is not a bit error
    assign monitored = busy_q &&
                       ((state_q == CRC) || (state_q == CRC_DEL) || (state_q == ACK_DEL) ||
                        ((state_q == EOF) && (cnt_q < CW'(EOF_LEN - 1))));
    assign bit_fail  = SP && monitored && (RX != tx_q);
    assign ack_fail  = SP && busy_q && (state_q == ACK_SLOT) && RX;

    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        idx_d      = idx_q;
        last_d     = last_q;
        run_d      = run_q;
        sent_all_d = sent_all_q;
        cnt_d      = cnt_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        fcrc_d     = fcrc_q;
        fack_d     = fack_q;
        ack_err_d  = ack_err_q;
        bit_err_d  = bit_err_q;

        if (!busy_q) begin
            if (START) begin
                crc_d      = CRC_IN;
                last_d     = PREV_BIT;
                run_d      = PREV_RUN;
                idx_d      = IW'(CRC_W - 1);
                sent_all_d = 1'b0;
                busy_d     = 1'b1;
                ack_err_d  = 1'b1;
                bit_err_d  = 1'b1;
                state_d    = IDLE;
            end
        end else if (bit_fail || ack_fail) begin
            // The SP check sees the current bit before any advance in the same clk
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            fcrc_d  = 1'b1;
            fack_d  = 1'b1;
            if (bit_fail) bit_err_d = 1'b0;
            if (ack_fail) ack_err_d = 1'b0;
        end else if (BIT_START) begin
            case (state_q)
                IDLE: begin
                    state_d = CRC;
                    tx_d    = data_bit;
                    last_d  = data_bit;
                    run_d   = data_run;
                    if (idx_q == '0) sent_all_d = 1'b1;
                    else             idx_d      = idx_q - IW'(1);
                end
                CRC: begin
                    if (run_q == 3'(STUFF_LIM)) begin
                        tx_d   = ~last_q;
                        last_d = ~last_q;
                        run_d  = 3'd1;
                    end else if (sent_all_q) begin
                        state_d = CRC_DEL;
                        tx_d    = 1'b1;
                        fcrc_d  = 1'b0;
                    end else begin
                        tx_d   = data_bit;
                        last_d = data_bit;
                        run_d  = data_run;
                        if (idx_q == '0) sent_all_d = 1'b1;
                        else             idx_d      = idx_q - IW'(1);
                    end
                end
                CRC_DEL: begin
                    state_d = ACK_SLOT;
                    tx_d    = 1'b1;
                    fcrc_d  = 1'b1;
                end
                ACK_SLOT: begin
                    state_d = ACK_DEL;
                    tx_d    = 1'b1;
                    fack_d  = 1'b0;
                end
                ACK_DEL: begin
                    state_d = EOF;
                    tx_d    = 1'b1;
                    fack_d  = 1'b1;
                    cnt_d   = '0;
                end
                EOF: begin
                    tx_d = 1'b1;
                    if (cnt_q == CW'(EOF_LEN - 1)) begin
                        state_d = IFS;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                IFS: begin
                    tx_d = 1'b1;
                    if (cnt_q == CW'(IFS_LEN - 1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign TX        = tx_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign F_CRC_D   = fcrc_q;
    assign F_ACK_D   = fack_q;
    assign ACK_Error = ack_err_q;
    assign BIT_Error = bit_err_q;

endmodule

// File: tb/tb_can_trailer_tx.sv
// tb/tb_can_trailer_tx.sv - scoreboard bench for can_trailer_tx
module tb_can_trailer_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        START = 1'b0;
    logic [14:0] CRC_IN = '0;
    logic        PREV_BIT = 1'b0;
    logic [2:0]  PREV_RUN = 3'd1;
    logic        BIT_START = 1'b0;
    logic        SP = 1'b0;
    logic        RX = 1'b1;
    logic        TX, BUSY, DONE, F_CRC_D, F_ACK_D, ACK_Error, BIT_Error;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic tx;
        logic fcrc;
        logic fack;
    } exp_t;

    exp_t exp_q[$];
    int   n_crc;

    can_trailer_tx dut (
        .clk(clk), .reset(reset), .START(START), .CRC_IN(CRC_IN),
        .PREV_BIT(PREV_BIT), .PREV_RUN(PREV_RUN), .BIT_START(BIT_START),
        .SP(SP), .RX(RX), .TX(TX), .BUSY(BUSY), .DONE(DONE),
        .F_CRC_D(F_CRC_D), .F_ACK_D(F_ACK_D),
        .ACK_Error(ACK_Error), .BIT_Error(BIT_Error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
        end
    endtask

    // Expected wire sequence: stuffed CRC, CRC del, ACK slot, ACK del, 7 EOF, 3 IFS
    task automatic build_exp(input logic [14:0] crc, input logic pb, input logic [2:0] pr);
        logic last;
        int   run;
        exp_q.delete();
        last = pb;
        run  = pr;
        for (int k = 14; k >= 0; k--) begin
            exp_q.push_back('{tx: crc[k], fcrc: 1'b1, fack: 1'b1});
            run  = (crc[k] == last) ? run + 1 : 1;
            last = crc[k];
            if (run == 5) begin
                exp_q.push_back('{tx: ~last, fcrc: 1'b1, fack: 1'b1});
                last = ~last;
                run  = 1;
            end
        end
        n_crc = exp_q.size();
        exp_q.push_back('{tx: 1'b1, fcrc: 1'b0, fack: 1'b1});
        exp_q.push_back('{tx: 1'b1, fcrc: 1'b1, fack: 1'b1});
        exp_q.push_back('{tx: 1'b1, fcrc: 1'b1, fack: 1'b0});
        for (int k = 0; k < 10; k++) exp_q.push_back('{tx: 1'b1, fcrc: 1'b1, fack: 1'b1});
    endtask

    task automatic run_frame(input string tag, input logic [14:0] crc, input logic pb,
                             input logic [2:0] pr, input int force_idx, input logic force_val,
                             input int reset_idx, input bit poke_busy);
        int   n;
        exp_t e;
        logic rx;
        bit   mon, exp_bit_err, exp_ack_err;
        build_exp(crc, pb, pr);
        n = exp_q.size();
        @(negedge clk);
        START = 1'b1; CRC_IN = crc; PREV_BIT = pb; PREV_RUN = pr;
        @(negedge clk);
        START = 1'b0;
        chk({tag, "_busy_after_start"}, BUSY, 1'b1);
        chk({tag, "_tx_after_start"}, TX, 1'b1);
        chk({tag, "_biterr_cleared"}, BIT_Error, 1'b1);
        chk({tag, "_ackerr_cleared"}, ACK_Error, 1'b1);
        if (poke_busy) begin
            START = 1'b1; CRC_IN = ~crc; PREV_BIT = ~pb; PREV_RUN = 3'd4;
            @(negedge clk);
            START = 1'b0;
        end
        for (int i = 0; i <= n; i++) begin
            BIT_START = 1'b1;
            @(negedge clk);
            BIT_START = 1'b0;
            if (i == n) begin
                chk({tag, "_done"}, DONE, 1'b1);
                chk({tag, "_busy_end"}, BUSY, 1'b0);
                chk({tag, "_tx_end"}, TX, 1'b1);
                chk({tag, "_biterr_end"}, BIT_Error, 1'b1);
                chk({tag, "_ackerr_end"}, ACK_Error, 1'b1);
                @(negedge clk);
                chk({tag, "_done_pulse"}, DONE, 1'b0);
                return;
            end
            e = exp_q.pop_front();
            chk($sformatf("%s_tx_bit%0d", tag, i), TX, e.tx);
            chk($sformatf("%s_fcrc_bit%0d", tag, i), F_CRC_D, e.fcrc);
            chk($sformatf("%s_fack_bit%0d", tag, i), F_ACK_D, e.fack);
            chk($sformatf("%s_nodone_bit%0d", tag, i), DONE, 1'b0);
            if (i == reset_idx) begin
                reset = 1'b0;
                #1;
                chk({tag, "_rst_tx"}, TX, 1'b1);
                chk({tag, "_rst_busy"}, BUSY, 1'b0);
                chk({tag, "_rst_done"}, DONE, 1'b0);
                chk({tag, "_rst_fcrc"}, F_CRC_D, 1'b1);
                chk({tag, "_rst_fack"}, F_ACK_D, 1'b1);
                chk({tag, "_rst_ackerr"}, ACK_Error, 1'b1);
                chk({tag, "_rst_biterr"}, BIT_Error, 1'b1);
                @(negedge clk);
                reset = 1'b1;
                exp_q.delete();
                return;
            end
            if (i == force_idx)      rx = force_val;
            else if (i == n_crc + 1) rx = 1'b0;
            else                     rx = e.tx;
            mon = (i <= n_crc) || (i == n_crc + 2) || (i >= n_crc + 3 && i < n_crc + 9);
            exp_bit_err = mon && (rx != e.tx);
            exp_ack_err = (i == n_crc + 1) && rx;
            RX = rx;
            SP = 1'b1;
            @(negedge clk);
            SP = 1'b0;
            RX = 1'b1;
            if (exp_bit_err || exp_ack_err) begin
                chk({tag, "_abort_biterr"}, BIT_Error, !exp_bit_err);
                chk({tag, "_abort_ackerr"}, ACK_Error, !exp_ack_err);
                chk({tag, "_abort_busy"}, BUSY, 1'b0);
                chk({tag, "_abort_tx"}, TX, 1'b1);
                chk({tag, "_abort_fcrc"}, F_CRC_D, 1'b1);
                chk({tag, "_abort_fack"}, F_ACK_D, 1'b1);
                BIT_START = 1'b1;
                @(negedge clk);
                BIT_START = 1'b0;
                chk({tag, "_abort_nodone"}, DONE, 1'b0);
                chk({tag, "_abort_tx_hold"}, TX, 1'b1);
                chk({tag, "_abort_flag_hold"}, BIT_Error & ACK_Error, 1'b0);
                exp_q.delete();
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_tx", TX, 1'b1);
        chk("reset_busy", BUSY, 1'b0);
        chk("reset_done", DONE, 1'b0);
        chk("reset_fcrc", F_CRC_D, 1'b1);
        chk("reset_fack", F_ACK_D, 1'b1);
        chk("reset_ackerr", ACK_Error, 1'b1);
        chk("reset_biterr", BIT_Error, 1'b1);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_frame("basic", 15'h4A3B, 1'b0, 3'd1, -1, 1'b0, -1, 1'b1);
    endtask

    task automatic test_stuffing();
        run_frame("stuff", 15'h0000, 1'b0, 3'd4, -1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_ack_error();
        run_frame("ackerr", 15'h0000, 1'b0, 3'd4, 18 + 1, 1'b1, -1, 1'b0);
    endtask

    task automatic test_bit_error();
        run_frame("biterr", 15'h7000, 1'b0, 3'd1, 2, 1'b0, -1, 1'b0);
    endtask

    task automatic test_last_eof();
        run_frame("lasteof", 15'h4A3B, 1'b0, 3'd1, 15 + 3 + 6, 1'b0, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_frame("rstmid", 15'h0000, 1'b0, 3'd4, -1, 1'b0, 18 + 3 + 2, 1'b0);
        run_frame("fresh", 15'h5555, 1'b1, 3'd3, -1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_a", 15'h7FFF, 1'b1, 3'd2, -1, 1'b0, -1, 1'b0);
        run_frame("b2b_b", 15'h1F07, 1'b0, 3'd3, -1, 1'b0, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stuffing();
        test_ack_error();
        test_bit_error();
        test_last_eof();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
